sd_cmd_fifo_master: RTL and testbench

Host-side command sequencer that sits directly upstream of the SD FIFO controller's 8-bit Wishbone slave port. It accepts one SD command (index, argument, response type) from a local control interface and serialises it into the tx command FIFO, polling the status register for space. It then polls for and drains the response bytes from the rx command FIFO, with a cycle-count timeout. It is the only master on that slave port while a command is in flight.

---
 rtl/sd_cmd_fifo_master_if.sv | 24 ++
 rtl/sd_cmd_fifo_master.sv | 233 +++++++++++++++++++++++
 tb/tb_sd_cmd_fifo_master.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_cmd_fifo_master_if.sv
// Wishbone link between the command sequencer and the SD FIFO
// controller's 8-bit slave port.
interface sd_cmd_fifo_master_if;
  logic [2:0] m_adr_o;
  logic [7:0] m_dat_o;
  logic [7:0] m_dat_i;
  logic       m_we_o;
  logic       m_cyc_o;
  logic       m_stb_o;
  logic [3:0] m_sel_o;
  logic       m_ack_i;

  modport master (
    output m_adr_o, m_dat_o, m_we_o,
    output m_cyc_o, m_stb_o, m_sel_o,
    input  m_dat_i, m_ack_i
  );

  modport slave (
    input  m_adr_o, m_dat_o, m_we_o,
    input  m_cyc_o, m_stb_o, m_sel_o,
    output m_dat_i, m_ack_i
  );
endinterface

// File: rtl/sd_cmd_fifo_master.sv
// SD command sequencer: pushes one 6-byte command into the tx FIFO and
// drains its response from the rx FIFO, polling status with a timeout.
module sd_cmd_fifo_master #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned POLL_GAP       = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_start_i,
  input  logic [5:0]  cmd_index_i,
  input  logic [31:0] cmd_arg_i,
  input  logic [1:0]  rsp_len_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic [7:0]  rsp_byte_o,
  output logic        rsp_valid_o,
  output logic        rsp_last_o,
  sd_cmd_fifo_master_if.master m
);

  typedef enum logic [2:0] {
    S_IDLE, S_TX_POLL, S_TX_GAP, S_TX_WR,
    S_RX_POLL, S_RX_GAP, S_RX_RD, S_DONE
  } state_e;

  localparam logic [1:0] P_ISSUE = 2'd0;
  localparam logic [1:0] P_WAIT  = 2'd1;
  localparam logic [1:0] P_DEC   = 2'd2;

  state_e      state_q;
  logic [1:0]  ph_q;
  logic [5:0]  idx_q;
  logic [31:0] arg_q;
  logic [1:0]  len_q;
  logic [2:0]  bcnt_q;
  logic [4:0]  rcnt_q;
  logic [3:0]  gcnt_q;
  logic [15:0] tcnt_q;
  logic [1:0]  stat_q;
  logic        busy_q, done_q, tmo_q;
  logic [7:0]  rsp_byte_q;
  logic        rsp_valid_q, rsp_last_q;
  logic [2:0]  adr_q;
  logic [7:0]  dat_q;
  logic        we_q, cyc_q, stb_q;

  logic [7:0]  tx_byte;
  logic [4:0]  n_bytes;
  logic        tmo_hit, gap_end, rx_last;

  always_comb begin
    tx_byte = 8'h00;
    unique case (bcnt_q)
      3'd0:    tx_byte = {2'b01, idx_q};
      3'd1:    tx_byte = arg_q[31:24];
      3'd2:    tx_byte = arg_q[23:16];
      3'd3:    tx_byte = arg_q[15:8];
      3'd4:    tx_byte = arg_q[7:0];
      3'd5:    tx_byte = {6'b0, len_q};
      default: tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    n_bytes = 5'd6;
    unique case (len_q)
      2'b00:   n_bytes = 5'd0;
      2'b10:   n_bytes = 5'd17;
      default: n_bytes = 5'd6;
    endcase
  end

  assign tmo_hit = tcnt_q >= 16'(TIMEOUT_CYCLES);
  assign gap_end = gcnt_q == 4'(POLL_GAP - 1);
  assign rx_last = (rcnt_q + 5'd1) == n_bytes;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      ph_q        <= P_ISSUE;
      idx_q       <= '0;
      arg_q       <= '0;
      len_q       <= '0;
      bcnt_q      <= '0;
      rcnt_q      <= '0;
      gcnt_q      <= '0;
      tcnt_q      <= '0;
      stat_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tmo_q       <= 1'b0;
      rsp_byte_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      if (state_q != S_IDLE && state_q != S_DONE && tcnt_q != 16'hFFFF)
        tcnt_q <= tcnt_q + 16'd1;
      case (state_q)
        S_IDLE: begin
          if (cmd_start_i) begin
            idx_q   <= cmd_index_i;
            arg_q   <= cmd_arg_i;
            len_q   <= rsp_len_i;
            bcnt_q  <= '0;
            rcnt_q  <= '0;
            tcnt_q  <= '0;
            tmo_q   <= 1'b0;
            busy_q  <= 1'b1;
            ph_q    <= P_ISSUE;
            state_q <= S_TX_POLL;
          end
        end
        S_TX_POLL, S_RX_POLL: begin
          // an in-flight status read always completes before timing out
          if (ph_q != P_WAIT && tmo_hit) begin
            done_q  <= 1'b1;
            tmo_q   <= 1'b1;
            state_q <= S_DONE;
          end else if (ph_q == P_ISSUE) begin
            cyc_q <= 1'b1;
            stb_q <= 1'b1;
            we_q  <= 1'b0;
            adr_q <= 3'd4;
            ph_q  <= P_WAIT;
          end else if (ph_q == P_WAIT) begin
            if (m.m_ack_i) begin
              cyc_q  <= 1'b0;
              stb_q  <= 1'b0;
              stat_q <= m.m_dat_i[1:0];
              ph_q   <= P_DEC;
            end
          end else begin
            ph_q   <= P_ISSUE;
            gcnt_q <= '0;
            if (state_q == S_TX_POLL)
              state_q <= stat_q[0] ? S_TX_GAP : S_TX_WR;
            else
              state_q <= stat_q[1] ? S_RX_GAP : S_RX_RD;
          end
        end
        S_TX_GAP, S_RX_GAP: begin
          if (tmo_hit) begin
            done_q  <= 1'b1;
            tmo_q   <= 1'b1;
            state_q <= S_DONE;
          end else if (gap_end) begin
            state_q <= (state_q == S_TX_GAP) ? S_TX_POLL : S_RX_POLL;
          end else begin
            gcnt_q <= gcnt_q + 4'd1;
          end
        end
        S_TX_WR: begin
          if (ph_q == P_ISSUE) begin
            cyc_q <= 1'b1;
            stb_q <= 1'b1;
            we_q  <= 1'b1;
            adr_q <= 3'd0;
            dat_q <= tx_byte;
            ph_q  <= P_WAIT;
          end else if (m.m_ack_i) begin
            cyc_q  <= 1'b0;
            stb_q  <= 1'b0;
            we_q   <= 1'b0;
            tcnt_q <= '0;
            ph_q   <= P_ISSUE;
            bcnt_q <= bcnt_q + 3'd1;
            if (bcnt_q != 3'd5) begin
              state_q <= S_TX_POLL;
            end else if (n_bytes == 5'd0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_RX_POLL;
            end
          end
        end
        S_RX_RD: begin
          if (ph_q == P_ISSUE) begin
            cyc_q <= 1'b1;
            stb_q <= 1'b1;
            we_q  <= 1'b0;
            adr_q <= 3'd1;
            ph_q  <= P_WAIT;
          end else if (m.m_ack_i) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            tcnt_q      <= '0;
            ph_q        <= P_ISSUE;
            rsp_byte_q  <= m.m_dat_i;
            rsp_valid_q <= 1'b1;
            rsp_last_q  <= rx_last;
            rcnt_q      <= rcnt_q + 5'd1;
            state_q     <= rx_last ? S_DONE : S_RX_POLL;
          end
        end
        S_DONE: begin
          // entered from the last rx read with done low so done trails rsp_valid
          if (!done_q) begin
            done_q <= 1'b1;
          end else begin
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign timeout_o   = tmo_q;
  assign rsp_byte_o  = rsp_byte_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_last_o  = rsp_last_q;
  assign m.m_adr_o   = adr_q;
  assign m.m_dat_o   = dat_q;
  assign m.m_we_o    = we_q;
  assign m.m_cyc_o   = cyc_q;
  assign m.m_stb_o   = stb_q;
  assign m.m_sel_o   = 4'b0001;

endmodule

// File: tb/tb_sd_cmd_fifo_master.sv
// Bench for sd_cmd_fifo_master: FIFO slave model with injectable full and
// empty status, plus a command/response reference model.
module tb_sd_cmd_fifo_master;
  localparam int TMO = 256;
  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  idx = '0;
  logic [31:0] arg = '0;
  logic [1:0]  len = '0;
  logic        busy, done, tmo, rv, rl;
  logic [7:0]  rb;
  logic        clr = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;

  int cfg_full_at = -1, cfg_full_polls = 0;
  int cfg_empty_at = -1, cfg_empty_polls = 0;
  logic [7:0] cfg_rx[$];

  logic [7:0] txlog[$];
  logic [7:0] rxq[$];
  int wcnt, stat_rd, xfers, rd_cnt, full_left, empty_left;
  int empty_poll_n[$];
  logic [7:0] st;

  logic [7:0] rsp_b[$];
  logic       rsp_l[$];
  int   done_n, done_at, last_wr_n, last_rv_n, prot_err;
  logic tmo_seen, ack_q;

  sd_cmd_fifo_master_if bus();

  sd_cmd_fifo_master #(.TIMEOUT_CYCLES(TMO), .POLL_GAP(GAP)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_start_i(start), .cmd_index_i(idx),
    .cmd_arg_i(arg), .rsp_len_i(len),
    .busy_o(busy), .done_o(done), .timeout_o(tmo),
    .rsp_byte_o(rb), .rsp_valid_o(rv), .rsp_last_o(rl),
    .m(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // slave: acks 2 cycles after stb, logs tx writes, serves rx bytes
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.m_ack_i <= 1'b0;
      bus.m_dat_i <= 8'h00;
      wcnt = 0;
    end else if (clr) begin
      bus.m_ack_i <= 1'b0;
      wcnt = 0; stat_rd = 0; xfers = 0; rd_cnt = 0;
      txlog.delete(); empty_poll_n.delete();
      rxq = cfg_rx;
      full_left = cfg_full_polls;
      empty_left = cfg_empty_polls;
    end else begin
      bus.m_ack_i <= 1'b0;
      if (bus.m_cyc_o && bus.m_stb_o && !bus.m_ack_i) begin
        if (wcnt == 1) begin
          wcnt = 0;
          bus.m_ack_i <= 1'b1;
          xfers++;
          if (bus.m_we_o) begin
            if (bus.m_adr_o == 3'd0) txlog.push_back(bus.m_dat_o);
          end else if (bus.m_adr_o == 3'd4) begin
            st = 8'h00;
            if (txlog.size() == cfg_full_at && full_left > 0) begin
              st[0] = 1'b1; full_left--;
            end
            if (rxq.size() == 0) st[1] = 1'b1;
            else if (rd_cnt == cfg_empty_at && empty_left > 0) begin
              st[1] = 1'b1; empty_left--;
            end
            if (st[1] && txlog.size() == 6) empty_poll_n.push_back(cyc_n);
            stat_rd++;
            bus.m_dat_i <= st;
          end else if (bus.m_adr_o == 3'd1) begin
            if (rxq.size() > 0) bus.m_dat_i <= rxq.pop_front();
            else bus.m_dat_i <= 8'hEE;
            rd_cnt++;
          end
        end else begin
          wcnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (clr) begin
      rsp_b.delete(); rsp_l.delete();
      done_n = 0; done_at = 0; last_wr_n = 0; last_rv_n = 0;
      prot_err = 0; tmo_seen = 1'b0;
    end else begin
      if (rv) begin
        rsp_b.push_back(rb); rsp_l.push_back(rl); last_rv_n = cyc_n;
      end
      if (done) begin
        done_n++; tmo_seen = tmo; done_at = cyc_n;
        if (!busy) prot_err++;
      end
      if (bus.m_ack_i && bus.m_cyc_o && bus.m_we_o) last_wr_n = cyc_n;
      if (ack_q && bus.m_cyc_o) prot_err++;
      if (bus.m_stb_o !== bus.m_cyc_o) prot_err++;
      if (bus.m_sel_o !== 4'b0001) prot_err++;
    end
    ack_q = bus.m_ack_i;
  end

  function automatic logic [7:0] m_tx(input logic [5:0] i,
      input logic [31:0] a, input logic [1:0] l, input int k);
    if (k == 0) return {2'b01, i};
    if (k == 5) return {6'b0, l};
    return a[8*(4-k) +: 8];
  endfunction

  function automatic int m_n(input logic [1:0] l);
    if (l == 2'b00) return 0;
    if (l == 2'b10) return 17;
    return 6;
  endfunction

  function automatic bit tx_ok(input logic [5:0] i,
      input logic [31:0] a, input logic [1:0] l);
    if (txlog.size() != 6) return 1'b0;
    for (int k = 0; k < 6; k++)
      if (txlog[k] !== m_tx(i, a, l, k)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit rsp_ok();
    if (rsp_b.size() != cfg_rx.size()) return 1'b0;
    foreach (cfg_rx[k]) if (rsp_b[k] !== cfg_rx[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit last_ok(input int n);
    int nl = 0;
    foreach (rsp_l[k]) if (rsp_l[k] === 1'b1) nl++;
    if (n == 0) return nl == 0;
    return nl == 1 && rsp_l.size() == n && rsp_l[n-1] === 1'b1;
  endfunction

  task automatic cfg(input int fa, input int fp, input int ea, input int ep, input int nrx);
    cfg_full_at = fa; cfg_full_polls = fp;
    cfg_empty_at = ea; cfg_empty_polls = ep;
    cfg_rx.delete();
    for (int k = 0; k < nrx; k++) cfg_rx.push_back(8'($urandom));
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic pulse(input logic [5:0] i, input logic [31:0] a, input logic [1:0] l);
    idx = i; arg = a; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      if (done_n != 0) begin got = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, tmo, rv, rl} !== 5'b0) begin
      bad++; $display("FAIL reset.flags got=%b want=00000", {busy, done, tmo, rv, rl});
    end
    total++;
    if (rb !== 8'h00) begin bad++; $display("FAIL reset.rsp_byte got=%h want=00", rb); end
    total++;
    if ({bus.m_cyc_o, bus.m_stb_o, bus.m_we_o, bus.m_adr_o, bus.m_dat_o} !== 14'd0) begin
      bad++; $display("FAIL reset.bus got=%b want=0", {bus.m_cyc_o, bus.m_stb_o, bus.m_we_o});
    end
    total++;
    if (bus.m_sel_o !== 4'b0001) begin bad++; $display("FAIL reset.sel got=%b want=0001", bus.m_sel_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_no_rsp();
    bit got;
    cfg(-1, 0, -1, 0, 0);
    pulse(6'd0, 32'd0, 2'b00);
    wait_done(got);
    total++;
    if (!got || tmo_seen !== 1'b0 || done_n != 1) begin
      bad++; $display("FAIL no_rsp.done got=%0d tmo=%b cnt=%0d want=1 0 1", got, tmo_seen, done_n);
    end
    total++;
    if (!tx_ok(6'd0, 32'd0, 2'b00)) begin bad++; $display("FAIL no_rsp.tx got=%p want=40 00 00 00 00 00", txlog); end
    total++;
    if (xfers != 12 || rsp_b.size() != 0) begin
      bad++; $display("FAIL no_rsp.xfers got=%0d rsp=%0d want=12 0", xfers, rsp_b.size());
    end
    total++;
    if (done_at - last_wr_n != 1 || prot_err != 0) begin
      bad++; $display("FAIL no_rsp.timing got=%0d err=%0d want=1 0", done_at - last_wr_n, prot_err);
    end
  endtask

  task automatic test_short_rsp();
    bit got;
    cfg(-1, 0, -1, 0, 0);
    for (int k = 0; k < 6; k++) cfg_rx.push_back(8'(8'h11 + k));
    clr = 1'b1; repeat (2) @(negedge clk); clr = 1'b0;
    pulse(6'd17, 32'h12345678, 2'b01);
    wait_done(got);
    total++;
    if (!got || tmo_seen !== 1'b0) begin bad++; $display("FAIL short.done got=%0d tmo=%b want=1 0", got, tmo_seen); end
    total++;
    if (!tx_ok(6'd17, 32'h12345678, 2'b01)) begin bad++; $display("FAIL short.tx got=%p want=51 12 34 56 78 01", txlog); end
    total++;
    if (!rsp_ok() || !last_ok(6)) begin bad++; $display("FAIL short.rsp got=%p last=%p want=%p", rsp_b, rsp_l, cfg_rx); end
    total++;
    if (done_at - last_rv_n != 1 || prot_err != 0) begin
      bad++; $display("FAIL short.timing got=%0d err=%0d want=1 0", done_at - last_rv_n, prot_err);
    end
  endtask

  task automatic test_long_rsp();
    bit got;
    int mind = 1000;
    logic [31:0] a = $urandom;
    cfg(-1, 0, 8, 20, 17);
    pulse(6'd2, a, 2'b10);
    wait_done(got);
    total++;
    if (!got || tmo_seen !== 1'b0) begin bad++; $display("FAIL long.done got=%0d tmo=%b want=1 0", got, tmo_seen); end
    total++;
    if (!tx_ok(6'd2, a, 2'b10) || !rsp_ok() || !last_ok(17)) begin
      bad++; $display("FAIL long.data tx=%p rsp=%p want=%p", txlog, rsp_b, cfg_rx);
    end
    for (int k = 1; k < empty_poll_n.size(); k++)
      if (empty_poll_n[k] - empty_poll_n[k-1] < mind) mind = empty_poll_n[k] - empty_poll_n[k-1];
    total++;
    if (empty_poll_n.size() != 20 || mind < GAP + 4) begin
      bad++; $display("FAIL long.polls got=%0d gap=%0d want=20 >=%0d", empty_poll_n.size(), mind, GAP + 4);
    end
  endtask

  task automatic test_tx_full();
    bit got;
    logic [5:0] i = 6'($urandom);
    logic [31:0] a = $urandom;
    cfg(3, 3, -1, 0, 6);
    pulse(i, a, 2'b11);
    wait_done(got);
    total++;
    if (!got || !tx_ok(i, a, 2'b11)) begin bad++; $display("FAIL tx_full.tx got=%p done=%0d", txlog, got); end
    total++;
    if (stat_rd != 15 || xfers != 27) begin
      bad++; $display("FAIL tx_full.polls got=%0d/%0d want=15/27", stat_rd, xfers);
    end
    total++;
    if (!rsp_ok() || !last_ok(6)) begin bad++; $display("FAIL tx_full.rsp got=%p want=%p", rsp_b, cfg_rx); end
  endtask

  task automatic test_timeout();
    bit got;
    int d;
    cfg(-1, 0, -1, 0, 0);
    pulse(6'd8, 32'h000001AA, 2'b01);
    wait_done(got);
    d = done_at - last_wr_n;
    total++;
    if (!got || tmo_seen !== 1'b1) begin bad++; $display("FAIL timeout.flag got=%0d tmo=%b want=1 1", got, tmo_seen); end
    total++;
    if (d < TMO || d > TMO + 16) begin bad++; $display("FAIL timeout.delay got=%0d want=%0d..%0d", d, TMO, TMO + 16); end
    total++;
    if (bus.m_cyc_o !== 1'b0 || busy !== 1'b0 || rsp_b.size() != 0) begin
      bad++; $display("FAIL timeout.idle cyc=%b busy=%b rsp=%0d want=0 0 0", bus.m_cyc_o, busy, rsp_b.size());
    end
  endtask

  task automatic test_busy_ignore();
    bit got;
    logic [5:0] i = 6'($urandom);
    logic [31:0] a = $urandom;
    cfg(-1, 0, -1, 0, 6);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL busy.idle got=%b want=0", busy); end
    pulse(i, a, 2'b01);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy.rise got=%b want=1", busy); end
    repeat (10) @(negedge clk);
    pulse(i ^ 6'h3F, ~a, 2'b00);
    wait_done(got);
    repeat (30) @(negedge clk);
    total++;
    if (!got || done_n != 1 || !tx_ok(i, a, 2'b01) || !rsp_ok()) begin
      bad++; $display("FAIL busy.ignore done=%0d tx=%p", done_n, txlog);
    end
  endtask

  task automatic test_reset_mid();
    bit hit = 1'b0;
    bit got;
    logic [5:0] i = 6'($urandom);
    logic [31:0] a = $urandom;
    cfg(-1, 0, -1, 0, 17);
    pulse(6'd5, $urandom, 2'b10);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (bus.m_cyc_o && !bus.m_we_o && bus.m_adr_o == 3'd1) begin hit = 1'b1; break; end
    end
    total++;
    if (!hit) begin bad++; $display("FAIL rst_mid.reach got=0 want=1"); end
    rst = 1'b1;
    #1;
    total++;
    if ({bus.m_cyc_o, bus.m_stb_o} !== 2'b00) begin
      bad++; $display("FAIL rst_mid.async got=%b want=00", {bus.m_cyc_o, bus.m_stb_o});
    end
    @(negedge clk);
    total++;
    if ({busy, done, tmo, rv, rl, rb} !== 13'd0) begin
      bad++; $display("FAIL rst_mid.outs got=%h want=0", {busy, done, tmo, rv, rl, rb});
    end
    rst = 1'b0;
    cfg(-1, 0, -1, 0, 0);
    pulse(i, a, 2'b00);
    wait_done(got);
    total++;
    if (!got || !tx_ok(i, a, 2'b00)) begin bad++; $display("FAIL rst_mid.restart got=%p done=%0d", txlog, got); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      bit got;
      logic [5:0] i = 6'($urandom);
      logic [31:0] a = $urandom;
      logic [1:0] l = 2'($urandom_range(0, 3));
      int n = m_n(l);
      int fp = $urandom_range(0, 3);
      int ep = (n > 0) ? $urandom_range(0, 6) : 0;
      int ea = (n > 0) ? $urandom_range(0, n - 1) : -1;
      int ex = 12 + fp + ((n > 0) ? 2 * n + ep : 0);
      cfg($urandom_range(0, 5), fp, ea, ep, n);
      pulse(i, a, l);
      wait_done(got);
      total++;
      if (!got || tmo_seen !== 1'b0 || !tx_ok(i, a, l)) begin
        bad++; $display("FAIL rand%0d.tx done=%0d tmo=%b got=%p", it, got, tmo_seen, txlog);
      end
      total++;
      if (!rsp_ok() || !last_ok(n)) begin
        bad++; $display("FAIL rand%0d.rsp got=%p want=%p", it, rsp_b, cfg_rx);
      end
      total++;
      if (xfers != ex || prot_err != 0) begin
        bad++; $display("FAIL rand%0d.xfers got=%0d err=%0d want=%0d 0", it, xfers, prot_err, ex);
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_rsp();
    test_short_rsp();
    test_long_rsp();
    test_tx_full();
    test_timeout();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
